// File: rtl/reg_dump.sv
// Register-file dump engine: walks indices 0..LAST_REG and streams each word out on a valid/ready port.
// Optional macro REG_DUMP_CHECKSUM_EN appends an XOR checksum beat after the last register.
module reg_dump #(
    parameter int unsigned LAST_REG = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  ra,
    input  logic [31:0] rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_IDX = 5'(LAST_REG);

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, READ, SEND, DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  ra_q, ra_d;
    logic [4:0]  oidx_q, oidx_d;
    logic [31:0] data_q, data_d;
    logic        last_q, last_d;
    logic        hs;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ra_q    <= '0;
            oidx_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ra_q    <= ra_d;
            oidx_q  <= oidx_d;
            data_q  <= data_d;
            last_q  <= last_d;
`ifdef REG_DUMP_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    assign out_valid = (state_q == SEND) || (state_q == CSUM);
`else
    assign out_valid = (state_q == SEND);
`endif
    assign hs       = out_valid && out_ready;
    assign out_data = data_q;
    assign out_idx  = oidx_q;
    assign out_last = last_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    // The read address tracks the counter only while capturing; otherwise it parks.
    assign ra = (state_q == READ) ? idx_q : ((state_q == IDLE) ? 5'd0 : ra_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ra_d    = ra_q;
        oidx_d  = oidx_q;
        data_d  = data_q;
        last_d  = last_q;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = READ;
                end
            end
            READ: begin
                ra_d    = idx_q;
                data_d  = rd;
                oidx_d  = idx_q;
`ifdef REG_DUMP_CHECKSUM_EN
                last_d  = 1'b0;
                csum_d  = csum_q ^ rd;
`else
                last_d  = (idx_q == LAST_IDX);
`endif
                state_d = SEND;
            end
            SEND: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        // csum_q already folds in the final word captured in READ.
                        data_d  = csum_q;
                        oidx_d  = '0;
                        last_d  = 1'b1;
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = READ;
                    end
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
                if (hs) state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over any handshake in the same cycle.
        if (abort && (state_q != IDLE)) state_d = IDLE;
    end

endmodule
